// File: rtl/m_csr_pkg.sv
// Shared types and constants for the m_csr CSR file and trap controller.
package m_csr_pkg;

  typedef struct packed {
    logic addr_valid;
  } lsu_to_csr_ctrl_t;

  typedef struct packed {
    logic [31:0] fault_addr;
  } lsu_to_csr_data_t;

  typedef struct packed {
    logic [31:0] satp;
    logic        mprv;
    logic [1:0]  mpp;
    logic        sum;
    logic        mxr;
  } csr_to_lsu_data_t;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_SIE      = 12'h104;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_SIP      = 12'h144;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
  localparam logic [3:0] EXC_ECALL_U        = 4'd8;
  localparam logic [3:0] EXC_ECALL_S        = 4'd9;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;
  localparam logic [3:0] EXC_INSTR_PAGE     = 4'd12;
  localparam logic [3:0] EXC_LOAD_PAGE      = 4'd13;
  localparam logic [3:0] EXC_STORE_PAGE     = 4'd15;

  localparam logic [3:0] IRQ_S_SOFT  = 4'd1;
  localparam logic [3:0] IRQ_M_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_S_TIMER = 4'd5;
  localparam logic [3:0] IRQ_M_TIMER = 4'd7;
  localparam logic [3:0] IRQ_S_EXT   = 4'd9;
  localparam logic [3:0] IRQ_M_EXT   = 4'd11;

  localparam logic [31:0] MISA_VAL      = 32'h4014_1105;
  localparam logic [31:0] MSTATUS_WMASK = 32'h007E_19AA;
  localparam logic [31:0] SSTATUS_MASK  = 32'h000C_0122;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0AAA;
  localparam logic [31:0] S_IRQ_MASK    = 32'h0000_0222;
  localparam logic [31:0] MEDELEG_MASK  = 32'h0000_F7FF;

  localparam int unsigned MS_SIE    = 1;
  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_SPIE   = 5;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_SPP    = 8;
  localparam int unsigned MS_MPP_LO = 11;
  localparam int unsigned MS_MPRV   = 17;
  localparam int unsigned MS_SUM    = 18;
  localparam int unsigned MS_MXR    = 19;

  // Only direct (00) and vectored (01) modes exist; anything else lands on direct.
  function automatic logic [31:0] tvec_legal(input logic [31:0] w);
    return {w[31:2], 1'b0, (w[1:0] == 2'b01)};
  endfunction

  // MPP=10 is a reserved privilege and is collapsed to U.
  function automatic logic [31:0] mstatus_merge(input logic [31:0] old_val,
                                                input logic [31:0] w,
                                                input logic [31:0] mask);
    logic [31:0] r;
    r = (old_val & ~mask) | (w & mask);
    if (r[12:11] == 2'b10) r[12:11] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/m_csr_irq_arbiter.sv
// Interrupt pending/enable/delegation qualification and fixed-priority cause selection.
module csr_irq_arbiter import m_csr_pkg::*; (
  input  logic [11:0] mip,
  input  logic [11:0] mie,
  input  logic [11:0] mideleg,
  input  logic [1:0]  priv,
  input  logic        m_ie,
  input  logic        s_ie,
  output logic        irq_pending,
  output logic [3:0]  irq_cause
);

  logic [11:0] active;
  logic [11:0] m_irq;
  logic [11:0] s_irq;
  logic [11:0] any_irq;
  logic        m_glob;
  logic        s_glob;

  assign active  = mip & mie;
  assign m_glob  = (priv != PRIV_M) | m_ie;
  assign s_glob  = (priv == PRIV_U) | ((priv == PRIV_S) & s_ie);
  assign m_irq   = active & ~mideleg & {12{m_glob}};
  assign s_irq   = active & mideleg & {12{s_glob}};
  assign any_irq = m_irq | s_irq;

  assign irq_pending = |any_irq;

  always_comb begin
    irq_cause = 4'd0;
    if      (any_irq[IRQ_M_EXT])   irq_cause = IRQ_M_EXT;
    else if (any_irq[IRQ_M_SOFT])  irq_cause = IRQ_M_SOFT;
    else if (any_irq[IRQ_M_TIMER]) irq_cause = IRQ_M_TIMER;
    else if (any_irq[IRQ_S_EXT])   irq_cause = IRQ_S_EXT;
    else if (any_irq[IRQ_S_SOFT])  irq_cause = IRQ_S_SOFT;
    else if (any_irq[IRQ_S_TIMER]) irq_cause = IRQ_S_TIMER;
  end

endmodule

// File: rtl/m_csr.sv
// M/S CSR file and trap controller: Zicsr access, traps, xRET, fetch redirect.
module m_csr import m_csr_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       csr_ops_in,
  input  logic [2:0]       sys_ops_in,
  input  logic             exc_req_in,
  input  logic [3:0]       exc_code_in,
  input  logic             irq_req_in,
  input  logic             csr_rd_req_in,
  input  logic             csr_wr_req_in,
  input  logic             fence_i_req_in,
  input  logic [11:0]      csr_addr_in,
  input  logic [31:0]      csr_wdata_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             instr_flushed_in,
  input  logic             pipe_stall_in,
  input  logic [31:0]      timer_val_low_in,
  input  logic [31:0]      timer_val_high_in,
  input  logic [31:0]      csr_mhartid_in,
  input  logic [1:0]       ext_irq_in,
  input  logic             timer_irq_in,
  input  logic             soft_irq_in,
  input  logic             uart_irq_in,
  input  lsu_to_csr_ctrl_t LSU_to_CSR_ctrl_in,
  input  lsu_to_csr_data_t LSU_to_CSR_data_in,
  output logic [31:0]      out,
  output logic [31:0]      csr_rdata_o,
  output logic             new_pc_req_o,
  output logic [31:0]      pc_new_o,
  output logic             irq_flush_lsu_o,
  output logic             wfi_req_o,
  output logic             csr_read_req_o,
  output logic [1:0]       priv_mode_o,
  output logic             irq_req_o,
  output csr_to_lsu_data_t CSR_to_LSU_data_out,
  output logic [31:0]      mcause_o,
  output logic [31:0]      mepc_o,
  output logic [31:0]      mtval_o
);

  logic [1:0]  priv;
  logic [31:0] mstatus, medeleg, mideleg, mie, mtvec, mscratch, mepc, mcause, mtval;
  logic [31:0] stvec, sscratch, sepc, scause, stval, satp;
  logic        ssip;
  logic [31:0] mip_rd, wval, tval, tvec_sel;
  logic        hit, commit, trap, trap_irq, deleg, irq_pend;
  logic        is_mret, is_sret, do_write;
  logic [3:0]  irq_cause, trap_code;
  logic        unused_addr_valid;

  assign unused_addr_valid = LSU_to_CSR_ctrl_in.addr_valid;

  always_comb begin
    mip_rd     = '0;
    mip_rd[1]  = ssip;
    mip_rd[3]  = soft_irq_in;
    mip_rd[7]  = timer_irq_in;
    mip_rd[9]  = ext_irq_in[1];
    mip_rd[11] = ext_irq_in[0] | uart_irq_in;
  end

  csr_irq_arbiter u_irq_arbiter (
    .mip         (mip_rd[11:0]),
    .mie         (mie[11:0]),
    .mideleg     (mideleg[11:0]),
    .priv        (priv),
    .m_ie        (mstatus[MS_MIE]),
    .s_ie        (mstatus[MS_SIE]),
    .irq_pending (irq_pend),
    .irq_cause   (irq_cause)
  );

  always_comb begin
    csr_rdata_o = '0;
    hit         = 1'b1;
    case (csr_addr_in)
      CSR_SSTATUS:  csr_rdata_o = mstatus & SSTATUS_MASK;
      CSR_SIE:      csr_rdata_o = mie & S_IRQ_MASK;
      CSR_STVEC:    csr_rdata_o = stvec;
      CSR_SSCRATCH: csr_rdata_o = sscratch;
      CSR_SEPC:     csr_rdata_o = sepc;
      CSR_SCAUSE:   csr_rdata_o = scause;
      CSR_STVAL:    csr_rdata_o = stval;
      CSR_SIP:      csr_rdata_o = mip_rd & S_IRQ_MASK;
      CSR_SATP:     csr_rdata_o = satp;
      CSR_MSTATUS:  csr_rdata_o = mstatus;
      CSR_MISA:     csr_rdata_o = MISA_VAL;
      CSR_MEDELEG:  csr_rdata_o = medeleg;
      CSR_MIDELEG:  csr_rdata_o = mideleg;
      CSR_MIE:      csr_rdata_o = mie;
      CSR_MTVEC:    csr_rdata_o = mtvec;
      CSR_MSCRATCH: csr_rdata_o = mscratch;
      CSR_MEPC:     csr_rdata_o = mepc;
      CSR_MCAUSE:   csr_rdata_o = mcause;
      CSR_MTVAL:    csr_rdata_o = mtval;
      CSR_MIP:      csr_rdata_o = mip_rd;
      CSR_TIME:     csr_rdata_o = timer_val_low_in;
      CSR_TIMEH:    csr_rdata_o = timer_val_high_in;
      CSR_MHARTID:  csr_rdata_o = csr_mhartid_in;
      default:      hit = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_ops_in)
      2'b10:   wval = csr_rdata_o | csr_wdata_in;
      2'b11:   wval = csr_rdata_o & ~csr_wdata_in;
      default: wval = csr_wdata_in;
    endcase
  end

  // An exception outranks a simultaneously accepted interrupt.
  assign commit    = ~instr_flushed_in & ~pipe_stall_in;
  assign trap_irq  = ~exc_req_in & irq_req_in & irq_pend;
  assign trap      = exc_req_in | trap_irq;
  assign trap_code = exc_req_in ? exc_code_in : irq_cause;
  assign deleg     = (priv != PRIV_M) & (trap_irq ? mideleg[trap_code] : medeleg[trap_code]);
  assign tvec_sel  = deleg ? stvec : mtvec;
  assign is_mret   = (sys_ops_in == 3'b001);
  assign is_sret   = (sys_ops_in == 3'b010);
  assign do_write  = csr_wr_req_in & (csr_ops_in != 2'b00) & ~trap & ~is_mret & ~is_sret
                     & ~fence_i_req_in;

  always_comb begin
    tval = '0;
    if (!trap_irq) begin
      case (exc_code_in)
        EXC_INSTR_MISALIGN, EXC_INSTR_FAULT, EXC_BREAKPOINT, EXC_INSTR_PAGE: tval = pc_in;
        EXC_ILLEGAL: tval = instr_in;
        EXC_LOAD_MISALIGN, EXC_LOAD_FAULT, EXC_STORE_MISALIGN, EXC_STORE_FAULT,
        EXC_LOAD_PAGE, EXC_STORE_PAGE: tval = LSU_to_CSR_data_in.fault_addr;
        default: tval = '0;
      endcase
    end
  end

  always_comb begin
    new_pc_req_o = 1'b1;
    pc_new_o     = '0;
    if (trap)
      pc_new_o = {tvec_sel[31:2], 2'b00}
               + ((trap_irq && tvec_sel[0]) ? {26'd0, trap_code, 2'b00} : 32'd0);
    else if (is_mret)        pc_new_o = mepc;
    else if (is_sret)        pc_new_o = sepc;
    else if (fence_i_req_in) pc_new_o = pc_in + 32'd4;
    else                     new_pc_req_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv     <= PRIV_M;
      mstatus  <= '0; medeleg <= '0; mideleg <= '0; mie <= '0; mtvec <= '0;
      mscratch <= '0; mepc <= '0; mcause <= '0; mtval <= '0; ssip <= 1'b0;
      stvec    <= '0; sscratch <= '0; sepc <= '0; scause <= '0; stval <= '0; satp <= '0;
    end else if (commit) begin
      if (trap) begin
        if (deleg) begin
          sepc              <= {pc_in[31:1], 1'b0};
          scause            <= {trap_irq, 27'd0, trap_code};
          stval             <= tval;
          mstatus[MS_SPIE]  <= mstatus[MS_SIE];
          mstatus[MS_SIE]   <= 1'b0;
          mstatus[MS_SPP]   <= priv[0];
          priv              <= PRIV_S;
        end else begin
          mepc                    <= {pc_in[31:1], 1'b0};
          mcause                  <= {trap_irq, 27'd0, trap_code};
          mtval                   <= tval;
          mstatus[MS_MPIE]        <= mstatus[MS_MIE];
          mstatus[MS_MIE]         <= 1'b0;
          mstatus[MS_MPP_LO +: 2] <= priv;
          priv                    <= PRIV_M;
        end
      end else if (is_mret) begin
        priv                    <= mstatus[MS_MPP_LO +: 2];
        mstatus[MS_MIE]         <= mstatus[MS_MPIE];
        mstatus[MS_MPIE]        <= 1'b1;
        mstatus[MS_MPP_LO +: 2] <= PRIV_U;
        if (mstatus[MS_MPP_LO +: 2] != PRIV_M) mstatus[MS_MPRV] <= 1'b0;
      end else if (is_sret) begin
        priv              <= {1'b0, mstatus[MS_SPP]};
        mstatus[MS_SIE]   <= mstatus[MS_SPIE];
        mstatus[MS_SPIE]  <= 1'b1;
        mstatus[MS_SPP]   <= 1'b0;
        mstatus[MS_MPRV]  <= 1'b0;
      end else if (do_write) begin
        case (csr_addr_in)
          CSR_SSTATUS:  mstatus  <= mstatus_merge(mstatus, wval, SSTATUS_MASK);
          CSR_SIE:      mie      <= (mie & ~S_IRQ_MASK) | (wval & S_IRQ_MASK);
          CSR_STVEC:    stvec    <= tvec_legal(wval);
          CSR_SSCRATCH: sscratch <= wval;
          CSR_SEPC:     sepc     <= {wval[31:1], 1'b0};
          CSR_SCAUSE:   scause   <= wval;
          CSR_STVAL:    stval    <= wval;
          CSR_SIP:      ssip     <= wval[1];
          CSR_SATP:     satp     <= wval;
          CSR_MSTATUS:  mstatus  <= mstatus_merge(mstatus, wval, MSTATUS_WMASK);
          CSR_MEDELEG:  medeleg  <= wval & MEDELEG_MASK;
          CSR_MIDELEG:  mideleg  <= wval & S_IRQ_MASK;
          CSR_MIE:      mie      <= wval & MIE_MASK;
          CSR_MTVEC:    mtvec    <= tvec_legal(wval);
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc     <= {wval[31:1], 1'b0};
          CSR_MCAUSE:   mcause   <= wval;
          CSR_MTVAL:    mtval    <= wval;
          CSR_MIP:      ssip     <= wval[1];
          default: ;
        endcase
      end
    end
  end

  assign out             = mstatus;
  assign priv_mode_o     = priv;
  assign mcause_o        = mcause;
  assign mepc_o          = mepc;
  assign mtval_o         = mtval;
  assign irq_req_o       = irq_pend;
  assign irq_flush_lsu_o = trap_irq;
  assign wfi_req_o       = (sys_ops_in == 3'b011) & ~irq_pend;
  assign csr_read_req_o  = csr_rd_req_in & hit;
  assign CSR_to_LSU_data_out = {satp, mstatus[MS_MPRV], mstatus[MS_MPP_LO +: 2],
                                mstatus[MS_SUM], mstatus[MS_MXR]};

endmodule

// File: tb/tb_m_csr.sv
// Self-checking bench for m_csr: directed trap/xRET scenarios plus randomized CSR traffic.
module tb_m_csr;
  import m_csr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]  csr_ops_in;
  logic [2:0]  sys_ops_in;
  logic        exc_req_in, irq_req_in, csr_rd_req_in, csr_wr_req_in, fence_i_req_in;
  logic [3:0]  exc_code_in;
  logic [11:0] csr_addr_in;
  logic [31:0] csr_wdata_in, pc_in, instr_in;
  logic        instr_flushed_in, pipe_stall_in;
  logic [31:0] timer_val_low_in, timer_val_high_in, csr_mhartid_in;
  logic [1:0]  ext_irq_in;
  logic        timer_irq_in, soft_irq_in, uart_irq_in;
  lsu_to_csr_ctrl_t LSU_to_CSR_ctrl_in;
  lsu_to_csr_data_t LSU_to_CSR_data_in;
  logic [31:0] out, csr_rdata_o, pc_new_o, mcause_o, mepc_o, mtval_o;
  logic        new_pc_req_o, irq_flush_lsu_o, wfi_req_o, csr_read_req_o, irq_req_o;
  logic [1:0]  priv_mode_o;
  csr_to_lsu_data_t CSR_to_LSU_data_out;

  always #5 clk = ~clk;

  m_csr dut (
    .clk(clk), .rst(rst), .csr_ops_in(csr_ops_in), .sys_ops_in(sys_ops_in),
    .exc_req_in(exc_req_in), .exc_code_in(exc_code_in), .irq_req_in(irq_req_in),
    .csr_rd_req_in(csr_rd_req_in), .csr_wr_req_in(csr_wr_req_in),
    .fence_i_req_in(fence_i_req_in), .csr_addr_in(csr_addr_in),
    .csr_wdata_in(csr_wdata_in), .pc_in(pc_in), .instr_in(instr_in),
    .instr_flushed_in(instr_flushed_in), .pipe_stall_in(pipe_stall_in),
    .timer_val_low_in(timer_val_low_in), .timer_val_high_in(timer_val_high_in),
    .csr_mhartid_in(csr_mhartid_in), .ext_irq_in(ext_irq_in),
    .timer_irq_in(timer_irq_in), .soft_irq_in(soft_irq_in), .uart_irq_in(uart_irq_in),
    .LSU_to_CSR_ctrl_in(LSU_to_CSR_ctrl_in), .LSU_to_CSR_data_in(LSU_to_CSR_data_in),
    .out(out), .csr_rdata_o(csr_rdata_o), .new_pc_req_o(new_pc_req_o),
    .pc_new_o(pc_new_o), .irq_flush_lsu_o(irq_flush_lsu_o), .wfi_req_o(wfi_req_o),
    .csr_read_req_o(csr_read_req_o), .priv_mode_o(priv_mode_o), .irq_req_o(irq_req_o),
    .CSR_to_LSU_data_out(CSR_to_LSU_data_out), .mcause_o(mcause_o), .mepc_o(mepc_o),
    .mtval_o(mtval_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Writable field sets, built from architectural bit positions.
  localparam logic [31:0] TB_MS_W = (32'd1 << 1) | (32'd1 << 3) | (32'd1 << 5) | (32'd1 << 7)
                                  | (32'd1 << 8) | (32'd3 << 11) | (32'd1 << 17) | (32'd1 << 18)
                                  | (32'd1 << 19) | (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 22);
  localparam logic [31:0] TB_SS_V = (32'd1 << 1) | (32'd1 << 5) | (32'd1 << 8)
                                  | (32'd1 << 18) | (32'd1 << 19);
  localparam logic [31:0] TB_S_IRQ = (32'd1 << 1) | (32'd1 << 5) | (32'd1 << 9);

  logic [31:0] mdl [logic [11:0]];
  logic [11:0] rnd_addrs [15] = '{CSR_MSCRATCH, CSR_SSCRATCH, CSR_SATP, CSR_MTVAL, CSR_MCAUSE,
                                  CSR_MEDELEG, CSR_MIDELEG, CSR_MIE, CSR_MSTATUS, CSR_MTVEC,
                                  CSR_MEPC, CSR_STVEC, CSR_SEPC, CSR_SSTATUS, CSR_SIE};

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    if (a == CSR_SSTATUS) return mdl[CSR_MSTATUS] & TB_SS_V;
    if (a == CSR_SIE)     return mdl[CSR_MIE] & TB_S_IRQ;
    return mdl[a];
  endfunction

  function automatic void mdl_write(input logic [11:0] a, input logic [31:0] v);
    logic [31:0] t;
    case (a)
      CSR_MSTATUS: begin
        t = (mdl[CSR_MSTATUS] & ~TB_MS_W) | (v & TB_MS_W);
        if (t[12:11] == 2'b10) t[12:11] = 2'b00;
        mdl[CSR_MSTATUS] = t;
      end
      CSR_SSTATUS: mdl[CSR_MSTATUS] = (mdl[CSR_MSTATUS] & ~TB_SS_V) | (v & TB_SS_V);
      CSR_SIE:     mdl[CSR_MIE] = (mdl[CSR_MIE] & ~TB_S_IRQ) | (v & TB_S_IRQ);
      CSR_MIE:     mdl[a] = v & 32'h0000_0AAA;
      CSR_MEDELEG: mdl[a] = v & 32'h0000_F7FF;
      CSR_MIDELEG: mdl[a] = v & TB_S_IRQ;
      CSR_MTVEC, CSR_STVEC: mdl[a] = (v & ~32'd3) | ((v[1:0] == 2'b01) ? 32'd1 : 32'd0);
      CSR_MEPC, CSR_SEPC:   mdl[a] = v & ~32'd1;
      default:     mdl[a] = v;
    endcase
  endfunction

  function automatic logic [31:0] exp_tval(input int code, input logic [31:0] pc,
                                           input logic [31:0] ins, input logic [31:0] fa);
    if (code == 0 || code == 1 || code == 3 || code == 12) return pc;
    if (code == 2) return ins;
    if ((code >= 4 && code <= 7) || code == 13 || code == 15) return fa;
    return 32'd0;
  endfunction

  task automatic idle();
    csr_ops_in = 0; sys_ops_in = 0; exc_req_in = 0; exc_code_in = 0; irq_req_in = 0;
    csr_rd_req_in = 0; csr_wr_req_in = 0; fence_i_req_in = 0; csr_addr_in = 0;
    csr_wdata_in = 0; pc_in = 0; instr_in = 0; instr_flushed_in = 0; pipe_stall_in = 0;
    timer_val_low_in = 32'h1234_5678; timer_val_high_in = 32'h0000_00AB;
    csr_mhartid_in = 32'h0000_0007; ext_irq_in = 0; timer_irq_in = 0; soft_irq_in = 0;
    uart_irq_in = 0; LSU_to_CSR_ctrl_in = '0; LSU_to_CSR_data_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr_in = a; csr_ops_in = op; csr_wdata_in = d; csr_wr_req_in = 1'b1;
    step();
    csr_wr_req_in = 1'b0; csr_ops_in = 2'b00;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr_in = a; csr_rd_req_in = 1'b1;
    #1 d = csr_rdata_o;
    csr_rd_req_in = 1'b0;
    #1;
  endtask

  logic [11:0] pl_addr [7] = '{CSR_MSCRATCH, CSR_MSTATUS, CSR_MIP, CSR_MIE, CSR_MEDELEG,
                               CSR_MTVEC, CSR_MTVAL};
  logic [31:0] pl_data [7] = '{32'h1111_2222, 32'h0000_1800, 32'h0000_0002, 32'h0000_0888,
                               32'h0000_FFFF, 32'h0000_2000, 32'hDEAD_BEEF};
  logic [31:0] pl_exp  [7] = '{32'h1111_2222, 32'h0000_1800, 32'h0000_0002, 32'h0000_0888,
                               32'h0000_F7FF, 32'h0000_2000, 32'hDEAD_BEEF};

  initial begin
    logic [31:0] rd, v, old_v, pc, ins, fa;
    logic [11:0] a;
    int op, code;

    do_reset();
    check_val("rst_priv", priv_mode_o, 32'd3);
    check_val("rst_mstatus", out, 32'd0);
    check_val("rst_mcause", mcause_o, 32'd0);
    check_val("rst_newpc", new_pc_req_o, 32'd0);
    check_val("rst_lsu_satp", CSR_to_LSU_data_out.satp, 32'd0);
    check_val("rst_lsu_bits", {27'd0, CSR_to_LSU_data_out[4:0]}, 32'd0);
    csr_rd(CSR_MISA, rd);    check_val("misa", rd, 32'h4014_1105);
    csr_rd(CSR_MHARTID, rd); check_val("mhartid", rd, 32'h0000_0007);
    csr_rd(CSR_TIMEH, rd);   check_val("timeh", rd, 32'h0000_00AB);
    csr_addr_in = 12'h7C0; csr_rd_req_in = 1'b1;
    #1 check_val("unimpl_rdata", csr_rdata_o, 32'd0);
    check_val("unimpl_rdreq", csr_read_req_o, 32'd0);
    csr_addr_in = CSR_MSCRATCH;
    #1 check_val("impl_rdreq", csr_read_req_o, 32'd1);
    csr_rd_req_in = 1'b0;

    for (int i = 0; i < 7; i++) csr_wr(pl_addr[i], 2'b01, pl_data[i]);
    for (int i = 0; i < 7; i++) begin
      csr_rd(pl_addr[i], rd);
      check_val($sformatf("plan_rd_%03h", pl_addr[i]), rd, pl_exp[i]);
    end

    pc_in = 32'h0000_ABCD; instr_in = 32'hDEAD_C0DE; exc_code_in = 4'd12; exc_req_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check_val("exc_pcnew", pc_new_o, 32'h0000_2000);
      check_val("exc_newreq", new_pc_req_o, 32'd1);
      step();
      check_val("exc_mepc", mepc_o, 32'h0000_ABCC);
      check_val("exc_mcause", mcause_o, 32'h0000_000C);
      check_val("exc_mtval", mtval_o, 32'h0000_ABCD);
      check_val("exc_priv", priv_mode_o, 32'd3);
    end
    exc_req_in = 1'b0;

    csr_wr(CSR_MSTATUS, 2'b10, 32'h0000_0008);
    csr_wr(CSR_MTVEC, 2'b01, 32'h0000_2001);
    timer_irq_in = 1'b1; sys_ops_in = 3'b011;
    #1 check_val("irq_pending", irq_req_o, 32'd1);
    check_val("wfi_blocked", wfi_req_o, 32'd0);
    sys_ops_in = 3'b000; pc_in = 32'h0000_3000; irq_req_in = 1'b1;
    #1 check_val("irq_pcnew", pc_new_o, 32'h0000_201C);
    check_val("irq_flush", irq_flush_lsu_o, 32'd1);
    step();
    irq_req_in = 1'b0;
    check_val("irq_mcause", mcause_o, 32'h8000_0007);
    check_val("irq_mepc", mepc_o, 32'h0000_3000);
    sys_ops_in = 3'b011;
    #1 check_val("irq_masked", irq_req_o, 32'd0);
    check_val("wfi_req", wfi_req_o, 32'd1);
    sys_ops_in = 3'b000; timer_irq_in = 1'b0;

    csr_wr(CSR_STVEC, 2'b01, 32'h0000_4000);
    csr_wr(CSR_MSTATUS, 2'b11, 32'h0000_1800);
    sys_ops_in = 3'b001;
    #1 check_val("mret_pcnew", pc_new_o, 32'h0000_3000);
    step();
    sys_ops_in = 3'b000;
    check_val("mret_priv", priv_mode_o, 32'd0);
    check_val("mret_mstatus", out, 32'h0000_0088);

    pc_in = 32'h0000_5002; instr_in = 32'h1234_5678; exc_code_in = 4'd2; exc_req_in = 1'b1;
    #1 check_val("sdeleg_pcnew", pc_new_o, 32'h0000_4000);
    step();
    exc_req_in = 1'b0;
    check_val("sdeleg_priv", priv_mode_o, 32'd1);
    check_val("sdeleg_mcause_kept", mcause_o, 32'h8000_0007);
    csr_rd(CSR_SCAUSE, rd); check_val("sdeleg_scause", rd, 32'h0000_0002);
    csr_rd(CSR_STVAL, rd);  check_val("sdeleg_stval", rd, 32'h1234_5678);
    csr_rd(CSR_SEPC, rd);   check_val("sdeleg_sepc", rd, 32'h0000_5002);

    fence_i_req_in = 1'b1; pc_in = 32'h0000_0100;
    #1 check_val("fencei_pc", pc_new_o, 32'h0000_0104);
    fence_i_req_in = 1'b0;

    csr_wr(CSR_MSCRATCH, 2'b01, 32'h0000_00F0);
    csr_wr(CSR_MSCRATCH, 2'b10, 32'h0000_000F);
    csr_rd(CSR_MSCRATCH, rd); check_val("set_op", rd, 32'h0000_00FF);
    csr_wr(CSR_MSCRATCH, 2'b11, 32'h0000_00F0);
    csr_rd(CSR_MSCRATCH, rd); check_val("clear_op", rd, 32'h0000_000F);
    pipe_stall_in = 1'b1;
    csr_wr(CSR_MSCRATCH, 2'b01, 32'h0000_0055);
    pipe_stall_in = 1'b0;
    csr_rd(CSR_MSCRATCH, rd); check_val("stall_nowrite", rd, 32'h0000_000F);
    instr_flushed_in = 1'b1;
    csr_wr(CSR_MSCRATCH, 2'b01, 32'h0000_0055);
    instr_flushed_in = 1'b0;
    csr_rd(CSR_MSCRATCH, rd); check_val("flush_nowrite", rd, 32'h0000_000F);

    do_reset();
    foreach (rnd_addrs[i]) mdl[rnd_addrs[i]] = 32'd0;
    for (int i = 0; i < 40; i++) begin
      a = rnd_addrs[$urandom_range(0, 14)];
      op = $urandom_range(1, 3);
      v = $urandom;
      old_v = mdl_read(a);
      if (op == 2) v = old_v | v;
      else if (op == 3) v = old_v & ~v;
      csr_wdata_in = 32'd0;
      mdl_write(a, v);
      csr_wr(a, op[1:0], (op == 1) ? v : ((op == 2) ? (v & ~old_v) | (v & old_v)
                                                     : ~v & old_v));
      csr_rd(a, rd);
      check_val($sformatf("rnd_csr_%03h", a), rd, mdl_read(a));
    end

    for (int i = 0; i < 12; i++) begin
      code = $urandom_range(0, 15);
      pc = $urandom; ins = $urandom; fa = $urandom;
      pc_in = pc; instr_in = ins; LSU_to_CSR_data_in.fault_addr = fa;
      exc_code_in = code[3:0]; exc_req_in = 1'b1;
      #1 check_val("rnd_exc_pcnew", pc_new_o, mdl_read(CSR_MTVEC) & ~32'd3);
      step();
      exc_req_in = 1'b0;
      check_val("rnd_exc_mepc", mepc_o, pc & ~32'd1);
      check_val("rnd_exc_mcause", mcause_o, code);
      check_val($sformatf("rnd_exc_mtval_c%0d", code), mtval_o, exp_tval(code, pc, ins, fa));
    end

    pc_in = 32'h0000_7777; exc_code_in = 4'd5; exc_req_in = 1'b1;
    #2 rst = 1'b1;
    #1 check_val("rst_async_mepc", mepc_o, 32'd0);
    check_val("rst_async_priv", priv_mode_o, 32'd3);
    step();
    exc_req_in = 1'b0;
    #1 check_val("rst_async_newpc", new_pc_req_o, 32'd0);
    rst = 1'b0;
    step();
    check_val("rst_async_mcause", mcause_o, 32'd0);
    check_val("rst_async_mstatus", out, 32'd0);
    csr_rd(CSR_MSCRATCH, rd); check_val("rst_async_mscratch", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
